conv_in_stage: RTL
==================

CONV_IN_STAGE -- requirements
Module: conv_in_stage

Interface
REQ-001 SHALL have parameter pDATA_WIDTH, default 8, bits per channel sample.
REQ-002 SHALL have parameter pIN_CHANNEL, default 3, channels packed per input word.
REQ-003 SHALL have parameter pFIFO_DEPTH, default 1024, FIFO entries; power of two, >=4.
REQ-004 SHALL have parameter pAF_MARGIN, default 4, free entries at or below which in_ready deasserts.
REQ-005 SHALL have parameters pINPUT_WIDTH, default 224, and pINPUT_HEIGHT, default 224, pixels per frame.
REQ-006 SHALL have ports clk (in, 1, sole clock) and rst (in, 1, asynchronous active-high reset).
REQ-007 SHALL have port en (in, 1) as the write strobe and port data_in (in, pDATA_WIDTH*pIN_CHANNEL) as the pixel word.
REQ-008 SHALL have port in_ready (out, 1), high while free entries > pAF_MARGIN.
REQ-009 SHALL have port load_weight (in, 1), which blocks reads while high.
REQ-010 SHALL have ports core_en (out, 1) = !empty && !load_weight, and rd_en (in, 1), the read request from the core.
REQ-011 SHALL have ports dout (out, pDATA_WIDTH*pIN_CHANNEL) and dout_valid (out, 1).
REQ-012 SHALL have ports full, empty (out, 1) and data_count (out, $clog2(pFIFO_DEPTH)+1).
REQ-013 SHALL have port frame_done (out, 1), a one-cycle pulse.

Function
REQ-014 Write accepted iff en && !full; data_in stored at the write pointer, pointer advances.
REQ-015 Read accepted iff rd_en && !empty && !load_weight; dout updates the next cycle with dout_valid=1 for exactly that cycle.
REQ-016 dout SHALL hold its last value when no read is accepted; dout_valid=0.
REQ-017 Simultaneous accepted read and write SHALL leave data_count unchanged; write while full and read accepted SHALL still be rejected (full evaluated pre-edge).
REQ-018 Write and read on empty: write accepted, read rejected; data available to read the next cycle.
REQ-019 full, empty and data_count SHALL be registered and consistent with each other every cycle; pointers wrap modulo pFIFO_DEPTH.
REQ-020 Pixel counter SHALL count accepted reads; on the read that brings it to pINPUT_WIDTH*pINPUT_HEIGHT, frame_done pulses coincident with that pixel's dout_valid, and the counter returns to 0.
REQ-021 load_weight rising mid-frame SHALL freeze reads and the pixel counter; writes continue.

Reset
REQ-022 rst asserted SHALL immediately force: pointers=0, data_count=0, empty=1, full=0, in_ready=1, dout=0, dout_valid=0, frame_done=0, pixel counter=0, status flags=0.
REQ-023 RAM contents SHALL NOT be reset; reset mid-frame discards all buffered pixels.

Configuration
REQ-024 With macro CONV_IN_STAGE_STATUS_EN defined, SHALL add input status_clr (1), sticky outputs overflow (en && full) and underflow (rd_en && empty && !load_weight), and high_water (data_count width) recording max data_count; status_clr clears all three, and an event in the same cycle as status_clr SHALL win.
REQ-025 Without CONV_IN_STAGE_STATUS_EN, those ports and registers SHALL NOT exist; rejected accesses are silently dropped.

Structure
REQ-026 Package conv_ip_pkg SHALL hold the pixel word typedef, the count-width constant function/localparams, and the frame-size constant computation.
REQ-027 Storage SHALL be sub-module conv_in_stage_ram: simple dual-port, one write port, one registered read port, no reset.

Verification (bench: pFIFO_DEPTH=16, pAF_MARGIN=4, 4x4 frame)
REQ-028 Reset, then write 16 words 0x000001..0x000010, no reads -> full=1, data_count=16, in_ready=0 after the 12th write; 17th write dropped (overflow=1 if enabled).
REQ-029 Read 16 words back-to-back -> dout = 0x000001..0x000010, each one cycle after its rd_en; empty=1 after the last; extra rd_en gives dout_valid=0 (underflow=1 if enabled).
REQ-030 Write and read every cycle at data_count=5 for 20 cycles -> data_count stays 5, in-order data, pointers wrap.
REQ-031 Stream 32 pixels, load_weight high for 10 cycles after pixel 7 -> no dout_valid during hold; frame_done pulses on pixels 16 and 32 only.
REQ-032 Assert rst asynchronously mid-frame with data_count=9 -> all outputs at reset values before the next clk edge; next frame_done after 16 new reads.

Source files
------------

// File: rtl/conv_in_stage_pkg.sv
// conv_ip_pkg -- shared types and sizing helpers for the convolution input stage.
//   pixel_t          : pixel word for the default 8-bit x 3-channel build
//   cnt_width()      : width of an occupancy count for a FIFO of a given depth
//   frame_size()     : pixels per frame
//   frame_cnt_width(): width of a counter able to index every pixel of a frame
package conv_ip_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_IN_CHANNEL = 3;
    localparam int DEF_WORD_WIDTH = DEF_DATA_WIDTH * DEF_IN_CHANNEL;

    typedef logic [DEF_WORD_WIDTH-1:0] pixel_t;

    // Occupancy must represent 0..depth inclusive, hence one extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int frame_size(input int width, input int height);
        return width * height;
    endfunction

    function automatic int frame_cnt_width(input int width, input int height);
        return $clog2(width * height + 1);
    endfunction

endpackage

// File: rtl/conv_in_stage_if.sv
// conv_in_stage_if -- pixel stream handshake between producer, input stage and core.
//   en, data_in, in_ready       : write side (producer -> stage)
//   rd_en, load_weight          : read request and read block from the core
//   core_en, dout, dout_valid   : read side (stage -> core)
// master: producer/core side that drives requests; slave: the input stage.
interface conv_in_stage_if #(
    parameter int pDATA_WIDTH = 8,
    parameter int pIN_CHANNEL = 3
);
    localparam int W = pDATA_WIDTH * pIN_CHANNEL;

    logic         en;
    logic [W-1:0] data_in;
    logic         in_ready;
    logic         load_weight;
    logic         rd_en;
    logic         core_en;
    logic [W-1:0] dout;
    logic         dout_valid;

    modport master (
        output en, data_in, load_weight, rd_en,
        input  in_ready, core_en, dout, dout_valid
    );

    modport slave (
        input  en, data_in, load_weight, rd_en,
        output in_ready, core_en, dout, dout_valid
    );
endinterface

// File: rtl/conv_in_stage_ram.sv
// conv_in_stage_ram -- simple dual-port storage for the input FIFO.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read port; rdata is registered and only updates when re is high
// Contents are deliberately not reset so the array maps onto block RAM.
module conv_in_stage_ram #(
    parameter int pWIDTH = 24,
    parameter int pDEPTH = 1024,
    localparam int AW    = $clog2(pDEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [pWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [pWIDTH-1:0] rdata
);
    logic [pWIDTH-1:0] mem_q [pDEPTH];
    logic [pWIDTH-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value between reads.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/conv_in_stage.sv
// conv_in_stage -- pixel FIFO feeding the convolution core, with frame tracking.
//   clk, rst     : clock, asynchronous active-high reset
//   bus (slave)  : en/data_in/in_ready write side, rd_en/load_weight/core_en/
//                  dout/dout_valid read side
//   full, empty, data_count : registered FIFO status
//   frame_done   : one-cycle pulse alongside the dout_valid of a frame's last pixel
// Optional macro CONV_IN_STAGE_STATUS_EN adds status_clr, sticky overflow/underflow
// and a high_water mark of data_count.
module conv_in_stage
    import conv_ip_pkg::*;
#(
    parameter int pDATA_WIDTH   = 8,
    parameter int pIN_CHANNEL   = 3,
    parameter int pFIFO_DEPTH   = 1024,
    parameter int pAF_MARGIN    = 4,
    parameter int pINPUT_WIDTH  = 224,
    parameter int pINPUT_HEIGHT = 224
) (
    input  logic                              clk,
    input  logic                              rst,
    conv_in_stage_if.slave                    bus,
    output logic                              full,
    output logic                              empty,
    output logic [cnt_width(pFIFO_DEPTH)-1:0] data_count,
    output logic                              frame_done
`ifdef CONV_IN_STAGE_STATUS_EN
    ,
    input  logic                              status_clr,
    output logic                              overflow,
    output logic                              underflow,
    output logic [cnt_width(pFIFO_DEPTH)-1:0] high_water
`endif
);
    localparam int DW    = pDATA_WIDTH * pIN_CHANNEL;
    localparam int AW    = $clog2(pFIFO_DEPTH);
    localparam int CW    = cnt_width(pFIFO_DEPTH);
    localparam int FRAME = frame_size(pINPUT_WIDTH, pINPUT_HEIGHT);
    localparam int FW    = frame_cnt_width(pINPUT_WIDTH, pINPUT_HEIGHT);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          in_ready_q, in_ready_d;
    logic          dout_valid_q, dout_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          loaded_q, loaded_d;
    logic [FW-1:0] pix_q, pix_d;
    logic [DW-1:0] ram_rdata;
    logic          wr_acc;
    logic          rd_acc;

    // Acceptance uses the registered flags, so a read in the same cycle never
    // frees space for a write while full, nor supplies data to a read while empty.
    assign wr_acc = bus.en && !full_q;
    assign rd_acc = bus.rd_en && !empty_q && !bus.load_weight;

    conv_in_stage_ram #(
        .pWIDTH (DW),
        .pDEPTH (pFIFO_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr_q),
        .wdata (bus.data_in),
        .re    (rd_acc),
        .raddr (rptr_q),
        .rdata (ram_rdata)
    );

    // Next-state for pointers, occupancy and derived flags.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_acc) begin
            wptr_d = wptr_q + AW'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (rd_acc) begin
            rptr_d = rptr_q + AW'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d     = (count_d == CW'(pFIFO_DEPTH));
        empty_d    = (count_d == {CW{1'b0}});
        in_ready_d = ((CW'(pFIFO_DEPTH) - count_d) > CW'(pAF_MARGIN));
    end

    // Next-state for the read-side outputs and the frame pixel counter.
    always_comb begin
        dout_valid_d = rd_acc;
        loaded_d     = loaded_q | rd_acc;
        pix_d        = pix_q;
        frame_done_d = 1'b0;
        if (rd_acc) begin
            if (pix_q == FW'(FRAME - 1)) begin
                pix_d        = {FW{1'b0}};
                frame_done_d = 1'b1;
            end else begin
                pix_d        = pix_q + FW'(1);
                frame_done_d = 1'b0;
            end
        end else begin
            pix_d        = pix_q;
            frame_done_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q       <= {AW{1'b0}};
            rptr_q       <= {AW{1'b0}};
            count_q      <= {CW{1'b0}};
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            in_ready_q   <= 1'b1;
            dout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            loaded_q     <= 1'b0;
            pix_q        <= {FW{1'b0}};
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            in_ready_q   <= in_ready_d;
            dout_valid_q <= dout_valid_d;
            frame_done_q <= frame_done_d;
            loaded_q     <= loaded_d;
            pix_q        <= pix_d;
        end
    end

    // The RAM read register has no reset; loaded_q masks it to zero until the
    // first read after reset so dout still comes out of reset as zero.
    assign bus.dout       = loaded_q ? ram_rdata : {DW{1'b0}};
    assign bus.dout_valid = dout_valid_q;
    assign bus.in_ready   = in_ready_q;
    assign bus.core_en    = !empty_q && !bus.load_weight;
    assign full           = full_q;
    assign empty          = empty_q;
    assign data_count     = count_q;
    assign frame_done     = frame_done_q;

`ifdef CONV_IN_STAGE_STATUS_EN
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic [CW-1:0] high_water_q, high_water_d;
    logic [CW-1:0] hw_base;

    // Sticky status; an event in the same cycle as status_clr wins over the clear.
    always_comb begin
        overflow_d   = status_clr ? 1'b0 : overflow_q;
        underflow_d  = status_clr ? 1'b0 : underflow_q;
        hw_base      = status_clr ? {CW{1'b0}} : high_water_q;
        high_water_d = hw_base;
        if (bus.en && full_q) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_d;
        end
        if (bus.rd_en && empty_q && !bus.load_weight) begin
            underflow_d = 1'b1;
        end else begin
            underflow_d = underflow_d;
        end
        if (count_d > hw_base) begin
            high_water_d = count_d;
        end else begin
            high_water_d = hw_base;
        end
    end

    // Status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            high_water_q <= {CW{1'b0}};
        end else begin
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            high_water_q <= high_water_d;
        end
    end

    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign high_water = high_water_q;
`endif
endmodule
